// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer for a registered 2-bit-op ALU, with shift-add multiply
module alu_sequencer #(
    parameter int ALU_LAT  = 1,
    parameter int MUL_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_res
);
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_n;
    logic        mul_q, mul_n;
    logic [31:0] a_q, a_n, b_q, b_n;
    logic [7:0]  wcnt, wcnt_n;
    logic [4:0]  icnt, icnt_n, icnt_inc;
    logic [31:0] res_data_n, alu_a_n, alu_b_n;
    logic        res_err_n;
    logic [1:0]  alu_op_n;

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign icnt_inc  = icnt + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mul_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            wcnt     <= '0;
            icnt     <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
        end else begin
            state    <= state_n;
            mul_q    <= mul_n;
            a_q      <= a_n;
            b_q      <= b_n;
            wcnt     <= wcnt_n;
            icnt     <= icnt_n;
            res_data <= res_data_n;
            res_err  <= res_err_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
            alu_op   <= alu_op_n;
        end
    end

    // During MUL, alu_a itself carries the running accumulator between iterations.
    always_comb begin
        state_n    = state;
        mul_n      = mul_q;
        a_n        = a_q;
        b_n        = b_q;
        wcnt_n     = wcnt;
        icnt_n     = icnt;
        res_data_n = res_data;
        res_err_n  = res_err;
        alu_a_n    = alu_a;
        alu_b_n    = alu_b;
        alu_op_n   = alu_op;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    a_n   = cmd_a;
                    b_n   = cmd_b;
                    mul_n = (cmd_op == OP_MUL);
                    if (cmd_op > OP_MUL) begin
                        res_data_n = '0;
                        res_err_n  = 1'b1;
                        state_n    = DONE;
                    end else begin
                        wcnt_n  = 8'(ALU_LAT);
                        icnt_n  = '0;
                        state_n = WAIT;
                        if (cmd_op == OP_MUL) begin
                            alu_a_n  = '0;
                            alu_b_n  = cmd_b[0] ? cmd_a : 32'd0;
                            alu_op_n = 2'd0;
                        end else begin
                            alu_a_n  = cmd_a;
                            alu_b_n  = cmd_b;
                            alu_op_n = cmd_op[1:0];
                        end
                    end
                end
            end
            WAIT: begin
                if (wcnt != 8'd0) begin
                    wcnt_n = wcnt - 8'd1;
                end else if (mul_q && (icnt != 5'(MUL_ITER - 1))) begin
                    icnt_n  = icnt_inc;
                    wcnt_n  = 8'(ALU_LAT);
                    alu_a_n = alu_res;
                    alu_b_n = b_q[icnt_inc] ? (a_q << icnt_inc) : 32'd0;
                end else begin
                    res_data_n = alu_res;
                    res_err_n  = 1'b0;
                    state_n    = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with a registered ALU model
module tb_alu_sequencer;
    localparam int MUL_ITER = 32;
    localparam int SINGLE_LAT = 2;
    localparam int MUL_LAT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [1:0]  alu_op;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.ALU_LAT(1), .MUL_ITER(MUL_ITER)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res)
    );

    // Registered ALU the sequencer is meant to drive
    always @(posedge clk or posedge reset) begin
        if (reset) alu_res <= '0;
        else case (alu_op)
            2'd0: alu_res <= alu_a + alu_b;
            2'd1: alu_res <= alu_a - alu_b;
            2'd2: alu_res <= alu_a ^ alu_b;
            default: alu_res <= (alu_a < alu_b) ? 32'd1 : 32'd0;
        endcase
    end

    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic err, output int lat);
        logic [63:0] mask;
        logic [63:0] prod;
        mask = (64'd1 << MUL_ITER) - 64'd1;
        err = 1'b0;
        lat = SINGLE_LAT;
        case (op)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a ^ b;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: begin
                prod = {32'd0, a} * ({32'd0, b} & mask);
                res = prod[31:0];
                lat = MUL_LAT;
            end
            default: begin
                res = 32'd0;
                err = 1'b1;
                lat = 0;
            end
        endcase
    endfunction

    // lat counts edges after the accepting edge until res_valid is seen
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_a = $urandom;
        cmd_b = $urandom;
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = res_data;
        err = res_err;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({cmd_ready, res_valid, res_err, res_data, alu_a, alu_b, alu_op} !== {1'b1, 1'b0, 1'b0, 98'd0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b val=%b err=%b data=%h a=%h b=%h op=%0d, need rdy=1 rest 0",
                     cmd_ready, res_valid, res_err, res_data, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_single_directed();
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd2};
        logic [31:0] as_ [5] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0};
        logic [31:0] bs_ [5] = '{32'd7, 32'd5, 32'd1, 32'hFFFFFFFF, 32'hFFFF0000};
        logic [31:0] want [5] = '{32'd12, 32'hFFFFFFFE, 32'd0, 32'd1, 32'h0F0FF0F0};
        logic [31:0] res;
        logic err;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_cmd(ops[i], as_[i], bs_[i], res, err, lat);
            n_cmp++;
            if (res !== want[i] || err !== 1'b0 || lat !== SINGLE_LAT) begin
                n_fail++;
                $display("FAIL single_dir[%0d]: got %h err=%b lat=%0d, need %h err=0 lat=%0d",
                         i, res, err, lat, want[i], SINGLE_LAT);
            end
        end
    endtask

    task automatic test_mul_directed();
        logic [31:0] res;
        logic err;
        int lat;
        run_cmd(3'd4, 32'h00010001, 32'h00010001, res, err, lat);
        n_cmp++;
        if (res !== 32'h00020001 || err !== 1'b0 || lat !== MUL_LAT) begin
            n_fail++;
            $display("FAIL mul_10001: got %h err=%b lat=%0d, need 00020001 err=0 lat=%0d", res, err, lat, MUL_LAT);
        end
        run_cmd(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, res, err, lat);
        n_cmp++;
        if (res !== 32'h00000001 || err !== 1'b0 || lat !== MUL_LAT) begin
            n_fail++;
            $display("FAIL mul_ffff: got %h err=%b lat=%0d, need 00000001 err=0 lat=%0d", res, err, lat, MUL_LAT);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] res;
        logic err;
        int lat;
        run_cmd(3'd0, 32'h1234_5678, 32'h0BAD_F00D, res, err, lat);
        run_cmd(3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, res, err, lat);
        n_cmp++;
        if (res !== 32'd0 || err !== 1'b1 || lat !== 0) begin
            n_fail++;
            $display("FAIL illegal_res: got %h err=%b lat=%0d, need 0 err=1 lat=0", res, err, lat);
        end
        n_cmp++;
        if (alu_a !== 32'h1234_5678 || alu_b !== 32'h0BAD_F00D || alu_op !== 2'd0) begin
            n_fail++;
            $display("FAIL illegal_alu_hold: a=%h b=%h op=%0d, need 12345678 0badf00d 0", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_a = 32'd100;
        cmd_b = 32'd58;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 32'd42 || res_err !== 1'b0 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: val=%b data=%h err=%b rdy=%b, need 1 0000002a 0 0",
                         c, res_valid, res_data, res_err, cmd_ready);
            end
            cmd_valid = (c == 2);
            cmd_op = 3'd0;
            cmd_a = 32'd9;
            cmd_b = 32'd9;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_handshake: rdy=%b val=%b, need rdy=1 val=0", cmd_ready, res_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] res;
        logic err;
        int lat;
        cmd_valid = 1'b1;
        cmd_op = 3'd4;
        cmd_a = 32'h0357_9BDF;
        cmd_b = 32'hFFFF_FFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_ready, res_valid, res_err, res_data, alu_a, alu_b, alu_op} !== {1'b1, 1'b0, 1'b0, 98'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_mul: rdy=%b val=%b err=%b data=%h a=%h b=%h op=%0d, need rdy=1 rest 0",
                     cmd_ready, res_valid, res_err, res_data, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_cmd(3'd0, 32'd2, 32'd2, res, err, lat);
        n_cmp++;
        if (res !== 32'd4 || err !== 1'b0 || lat !== SINGLE_LAT) begin
            n_fail++;
            $display("FAIL add_after_reset: got %h err=%b lat=%0d, need 4 err=0 lat=%0d", res, err, lat, SINGLE_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp_res;
        logic err, exp_err;
        int lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            ref_model(op, a, b, exp_res, exp_err, exp_lat);
            run_cmd(op, a, b, res, err, lat);
            n_cmp++;
            if (res !== exp_res || err !== exp_err || lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h err=%b lat=%0d, need %h err=%b lat=%0d",
                         i, op, a, b, res, err, lat, exp_res, exp_err, exp_lat);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_directed();
        test_mul_directed();
        test_illegal();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
